game_tick_sequencer: RTL and testbench

- Consumer end of the game clock interface. Takes the main tick pulse and the early tick pulse, which arrives 255 CLOCK_50 cycles before each main tick.
- Samples player input on early ticks and advances an obstacle lane on main ticks.
- Detects collisions and keeps score.
- Drives key_press back to the clock block, which restores the starting tick rate when a new game begins.

---
 rtl/game_pkg.sv | 21 ++
 rtl/edge_sync.sv | 26 ++
 rtl/game_tick_sequencer.sv | 112 +++++++++++
 tb/tb_game_tick_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, LFSR taps and default parameters for the game tick sequencer
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam int         DEF_DEPTH      = 16;
    localparam int         DEF_JUMP_TICKS = 3;
    localparam int         DEF_SCORE_W    = 16;
    localparam logic [7:0] DEF_LFSR_SEED  = 8'hA5;

    // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-flop synchroniser followed by a rising-edge detector
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q;

    // synchronise the raw pin and keep one extra stage for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer: runs the obstacle lane, jump timing, collisions and score from game clock ticks
module game_tick_sequencer
    import game_pkg::*;
#(
    parameter int         DEPTH      = DEF_DEPTH,
    parameter int         JUMP_TICKS = DEF_JUMP_TICKS,
    parameter int         SCORE_W    = DEF_SCORE_W,
    parameter logic [7:0] LFSR_SEED  = DEF_LFSR_SEED
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               NEW_PULSE,
    input  logic               NEW_PULSE_EARLY,
    input  logic               key_jump,
    input  logic               key_start,
    output logic               key_press,
    output logic [DEPTH-1:0]   obstacle_map,
    output logic               player_up,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [1:0]         state
);

    localparam int AW = $clog2(JUMP_TICKS + 1);

    state_t             state_q;
    logic               key_press_q;
    logic [DEPTH-1:0]   map_q, map_d;
    logic               player_up_q, up_e, up_d;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [AW-1:0]      air_q, air_e, air_d;
    logic               jump_pending_q, pend_eff, take, crash;
    logic               jump_rise, start_rise;

    edge_sync u_jump (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .d_i    (key_jump),
        .rise_o (jump_rise)
    );

    edge_sync u_start (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .d_i    (key_start),
        .rise_o (start_rise)
    );

    // early tick samples the jump first, then the main tick advances lane and air time on top of it
    always_comb begin
        lfsr_d   = lfsr_next(lfsr_q);
        map_d    = {lfsr_d[1] & lfsr_d[0] & ~map_q[DEPTH-1], map_q[DEPTH-1:1]};
        pend_eff = jump_pending_q | (jump_rise & ~player_up_q);
        take     = NEW_PULSE_EARLY & pend_eff;
        air_e    = take ? AW'(JUMP_TICKS) : air_q;
        up_e     = take | player_up_q;
        air_d    = (NEW_PULSE && air_e != '0) ? air_e - 1'b1 : air_e;
        up_d     = (NEW_PULSE && air_e == AW'(1)) ? 1'b0 : up_e;
        crash    = map_d[0] & ~up_d;
    end

    // game FSM with all registered outputs; ticks only matter in RUN, start edges only outside it
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            key_press_q    <= 1'b0;
            map_q          <= '0;
            player_up_q    <= 1'b0;
            score_q        <= '0;
            lfsr_q         <= LFSR_SEED;
            air_q          <= '0;
            jump_pending_q <= 1'b0;
        end else begin
            key_press_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    player_up_q    <= up_d;
                    air_q          <= air_d;
                    jump_pending_q <= pend_eff & ~take;
                    if (NEW_PULSE) begin
                        lfsr_q <= lfsr_d;
                        map_q  <= map_d;
                        if (crash)
                            state_q <= ST_OVER;
                        else if (score_q != '1)
                            score_q <= score_q + 1'b1;
                    end
                end
                default: begin
                    if (start_rise) begin
                        state_q        <= ST_RUN;
                        key_press_q    <= 1'b1;
                        map_q          <= '0;
                        player_up_q    <= 1'b0;
                        score_q        <= '0;
                        air_q          <= '0;
                        jump_pending_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign key_press    = key_press_q;
    assign obstacle_map = map_q;
    assign player_up    = player_up_q;
    assign score        = score_q;
    assign game_over    = (state_q == ST_OVER);
    assign state        = state_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb_game_tick_sequencer: directed and random stimulus checked against a behavioural game model
module tb_game_tick_sequencer;

    localparam int D  = 16;
    localparam int JT = 3;
    localparam int SMAX = 65535;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          NEW_PULSE = 1'b0;
    logic          NEW_PULSE_EARLY = 1'b0;
    logic          key_jump = 1'b0;
    logic          key_start = 1'b0;
    logic          key_press;
    logic [D-1:0]  obstacle_map;
    logic          player_up;
    logic [15:0]   score;
    logic          game_over;
    logic [1:0]    state;

    int n_chk = 0;
    int n_fail = 0;

    int m_st, m_score, m_air, m_kp, m_lfsr;
    bit m_up, m_pend;
    bit lane[D];
    bit jh[4];
    bit sh[4];
    bit started = 0;

    game_tick_sequencer dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .NEW_PULSE       (NEW_PULSE),
        .NEW_PULSE_EARLY (NEW_PULSE_EARLY),
        .key_jump        (key_jump),
        .key_start       (key_start),
        .key_press       (key_press),
        .obstacle_map    (obstacle_map),
        .player_up       (player_up),
        .score           (score),
        .game_over       (game_over),
        .state           (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] lane_bits();
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[i] = lane[i];
        return v;
    endfunction

    task automatic model_step();
        bit jedge, sedge, eff, nb;
        int fb;
        if (reset) begin
            m_st = 0; m_score = 0; m_air = 0; m_kp = 0; m_lfsr = 8'hA5;
            m_up = 0; m_pend = 0;
            for (int i = 0; i < D; i++) lane[i] = 0;
            for (int i = 0; i < 4; i++) begin jh[i] = 0; sh[i] = 0; end
            return;
        end
        for (int i = 3; i > 0; i--) begin jh[i] = jh[i-1]; sh[i] = sh[i-1]; end
        jh[0] = key_jump;
        sh[0] = key_start;
        jedge = jh[2] && !jh[3];
        sedge = sh[2] && !sh[3];
        m_kp = 0;
        if (m_st != 1) begin
            if (sedge) begin
                m_st = 1; m_kp = 1; m_score = 0; m_up = 0; m_air = 0; m_pend = 0;
                for (int i = 0; i < D; i++) lane[i] = 0;
            end
        end else begin
            eff = m_pend || (jedge && !m_up);
            if (NEW_PULSE_EARLY && eff) begin
                m_up = 1; m_air = JT; m_pend = 0;
            end else m_pend = eff;
            if (NEW_PULSE) begin
                fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                m_lfsr = ((m_lfsr << 1) | fb) & 255;
                nb = ((m_lfsr & 3) == 3) && !lane[D-1];
                for (int i = 0; i < D - 1; i++) lane[i] = lane[i+1];
                lane[D-1] = nb;
                if (m_air > 0) begin
                    m_air--;
                    if (m_air == 0) m_up = 0;
                end
                if (lane[0] && !m_up) m_st = 2;
                else if (m_score < SMAX) m_score++;
            end
        end
    endtask

    always @(posedge CLOCK_50) begin
        model_step();
        started = 1;
        #1;
        chk("state", state, m_st);
        chk("key_press", key_press, m_kp);
        chk("obstacle_map", obstacle_map, lane_bits());
        chk("player_up", player_up, m_up);
        chk("score", score, m_score);
        chk("game_over", game_over, m_st == 2);
        chk("no_adjacent", (obstacle_map & (obstacle_map >> 1)) == 0, 1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pulse();
        NEW_PULSE = 1'b1;
        @(negedge CLOCK_50);
        NEW_PULSE = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic start_game();
        int hits, first;
        hits = 0;
        first = 0;
        key_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLOCK_50);
            if (key_press) begin
                hits++;
                if (first == 0) first = i;
            end
        end
        key_start = 1'b0;
        cyc(3);
        chk("kp_count", hits, 1);
        chk("kp_delay", first, 3);
        chk("start_state", state, 1);
        chk("start_score", score, 0);
        chk("start_map", obstacle_map, 0);
    endtask

    initial begin
        int prev;
        logic [D-1:0] snap;
        bit found;
        cyc(3);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_state", state, 0);
        chk("rst_score", score, 0);
        chk("rst_map", obstacle_map, 0);
        chk("rst_kp", key_press, 0);
        chk("rst_over", game_over, 0);

        start_game();
        for (int i = 0; i < 20; i++) pulse();
        chk("score20", score, 20);
        chk("bit0_clear", obstacle_map[0], 0);
        chk("bit1_set", obstacle_map[1], 1);

        key_jump = 1'b1;
        cyc(4);
        key_jump = 1'b0;
        cyc(2);
        NEW_PULSE_EARLY = 1'b1;
        @(negedge CLOCK_50);
        NEW_PULSE_EARLY = 1'b0;
        cyc(2);
        pulse();
        chk("jump_up", player_up, 1);
        chk("jump_run", state, 1);
        chk("jump_score", score, 21);
        repeat (3) pulse();
        chk("land_up", player_up, 0);
        chk("land_run", state, 1);
        chk("land_score", score, 24);

        prev = m_score;
        for (int n = 0; n < 300 && m_st != 2; n++) begin
            prev = m_score;
            pulse();
        end
        chk("over_state", state, 2);
        chk("over_flag", game_over, 1);
        chk("over_score", score, prev);
        snap = lane_bits();
        prev = m_score;
        repeat (3) pulse();
        NEW_PULSE_EARLY = 1'b1;
        @(negedge CLOCK_50);
        NEW_PULSE_EARLY = 1'b0;
        chk("over_map_frozen", obstacle_map, snap);
        chk("over_score_frozen", score, prev);
        chk("over_stays", state, 2);

        start_game();
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (m_st != 1) start_game();
            else if (lane[1] && !m_up) found = 1;
            else pulse();
        end
        chk("same_cycle_setup", found, 1);
        cyc(4);
        key_jump = 1'b1;
        cyc(2);
        NEW_PULSE = 1'b1;
        NEW_PULSE_EARLY = 1'b1;
        @(negedge CLOCK_50);
        NEW_PULSE = 1'b0;
        NEW_PULSE_EARLY = 1'b0;
        key_jump = 1'b0;
        chk("same_cycle_state", state, 1);
        chk("same_cycle_up", player_up, 1);
        cyc(4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) key_jump = ~key_jump;
            key_start       = ($urandom_range(63) == 0);
            NEW_PULSE       = ($urandom_range(5) == 0);
            NEW_PULSE_EARLY = ($urandom_range(5) == 0);
            reset           = ($urandom_range(499) == 0);
            @(negedge CLOCK_50);
        end
        key_jump = 1'b0;
        key_start = 1'b0;
        NEW_PULSE = 1'b0;
        NEW_PULSE_EARLY = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        cyc(4);

        start_game();
        repeat (7) pulse();
        chk("score7", score, 7);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("midrst_state", state, 0);
        chk("midrst_score", score, 0);
        chk("midrst_kp", key_press, 0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("midrst_kp_after", key_press, 0);
        chk("midrst_idle", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
